// File: rtl/qsn_layer_sched.sv
// Schedules quasi-cyclic shift network beats from a small programmable base-matrix table.
// Walks the table for a number of iterations, skips null entries and issues beats over valid/ready.
module qsn_layer_sched #(
  parameter int unsigned LIFTING_FACTOR = 4,
  parameter int unsigned SHIFT_WIDTH    = 2,
  parameter int unsigned NUM_ENTRIES    = 8,
  parameter int unsigned ADDR_WIDTH     = 3,
  parameter int unsigned COL_WIDTH      = 3,
  parameter int unsigned ITER_WIDTH     = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_we,
  input  logic [ADDR_WIDTH-1:0]  cfg_addr,
  input  logic [COL_WIDTH-1:0]   cfg_col,
  input  logic [SHIFT_WIDTH-1:0] cfg_shift,
  input  logic                   cfg_null,
  input  logic [ADDR_WIDTH:0]    cfg_len,
  input  logic [ITER_WIDTH-1:0]  iterations,
  input  logic                   start,
  input  logic                   abort,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [SHIFT_WIDTH-1:0] qsn_shift,
  output logic [COL_WIDTH-1:0]   out_col,
  output logic                   out_last,
  output logic [ITER_WIDTH-1:0]  iter_idx,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned LEN_WIDTH = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e                 state_q, state_d;
  logic [COL_WIDTH-1:0]   tbl_col_q   [NUM_ENTRIES];
  logic [COL_WIDTH-1:0]   tbl_col_d   [NUM_ENTRIES];
  logic [SHIFT_WIDTH-1:0] tbl_shift_q [NUM_ENTRIES];
  logic [SHIFT_WIDTH-1:0] tbl_shift_d [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] tbl_null_q, tbl_null_d;

  logic [ADDR_WIDTH-1:0]  ptr_q, ptr_d;
  logic [ITER_WIDTH-1:0]  iter_cnt_q, iter_cnt_d;
  logic [LEN_WIDTH-1:0]   len_q, len_d;
  logic [ITER_WIDTH-1:0]  iter_lim_q, iter_lim_d;
  logic                   scan_done_q, scan_done_d;

  logic                   out_valid_q, out_valid_d;
  logic [SHIFT_WIDTH-1:0] qsn_shift_q, qsn_shift_d;
  logic [COL_WIDTH-1:0]   out_col_q, out_col_d;
  logic                   out_last_q, out_last_d;
  logic [ITER_WIDTH-1:0]  iter_idx_q, iter_idx_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic                   more_nonnull;
  logic                   wrap;
  logic                   last_iter;

  // Table writes, accepted only while idle; shifts folded into the legal range.
  always_comb begin
    tbl_col_d   = tbl_col_q;
    tbl_shift_d = tbl_shift_q;
    tbl_null_d  = tbl_null_q;
    if (cfg_we && (state_q == S_IDLE)) begin
      tbl_col_d[cfg_addr]   = cfg_col;
      tbl_shift_d[cfg_addr] = SHIFT_WIDTH'(32'(cfg_shift) % LIFTING_FACTOR);
      tbl_null_d[cfg_addr]  = cfg_null;
    end
  end

  // Any non-null entry left beyond ptr within the active length?
  always_comb begin
    more_nonnull = 1'b0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if ((i > int'(ptr_q)) && (i < int'(len_q)) && !tbl_null_q[i]) begin
        more_nonnull = 1'b1;
      end
    end
  end

  assign wrap      = (({1'b0, ptr_q} + LEN_WIDTH'(1)) == len_q);
  assign last_iter = (iter_cnt_q == (iter_lim_q - ITER_WIDTH'(1)));

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    iter_cnt_d  = iter_cnt_q;
    len_d       = len_q;
    iter_lim_d  = iter_lim_q;
    scan_done_d = scan_done_q;
    out_valid_d = out_valid_q;
    qsn_shift_d = qsn_shift_q;
    out_col_d   = out_col_q;
    out_last_d  = out_last_q;
    iter_idx_d  = iter_idx_q;
    done_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          ptr_d       = '0;
          iter_cnt_d  = '0;
          iter_idx_d  = '0;
          scan_done_d = 1'b0;
          len_d       = (cfg_len > LEN_WIDTH'(NUM_ENTRIES)) ? LEN_WIDTH'(NUM_ENTRIES) : cfg_len;
          iter_lim_d  = iterations;
          if ((cfg_len == '0) || (iterations == '0)) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d     = S_DONE;
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          done_d      = 1'b1;
        end else if (!(out_valid_q && !out_ready)) begin
          // Free cycle: the pending beat (if any) transfers, scan the next entry.
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          if (scan_done_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            iter_idx_d = iter_cnt_q;
            if (!tbl_null_q[ptr_q]) begin
              out_valid_d = 1'b1;
              qsn_shift_d = tbl_shift_q[ptr_q];
              out_col_d   = tbl_col_q[ptr_q];
              out_last_d  = !more_nonnull;
            end
            if (wrap) begin
              ptr_d      = '0;
              iter_cnt_d = iter_cnt_q + ITER_WIDTH'(1);
              if (last_iter) begin
                scan_done_d = 1'b1;
              end
            end else begin
              ptr_d = ptr_q + ADDR_WIDTH'(1);
            end
          end
        end
      end
      S_DONE: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      tbl_null_q  <= '1;
      ptr_q       <= '0;
      iter_cnt_q  <= '0;
      len_q       <= '0;
      iter_lim_q  <= '0;
      scan_done_q <= 1'b0;
      out_valid_q <= 1'b0;
      qsn_shift_q <= '0;
      out_col_q   <= '0;
      out_last_q  <= 1'b0;
      iter_idx_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        tbl_col_q[i]   <= '0;
        tbl_shift_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      tbl_null_q  <= tbl_null_d;
      ptr_q       <= ptr_d;
      iter_cnt_q  <= iter_cnt_d;
      len_q       <= len_d;
      iter_lim_q  <= iter_lim_d;
      scan_done_q <= scan_done_d;
      out_valid_q <= out_valid_d;
      qsn_shift_q <= qsn_shift_d;
      out_col_q   <= out_col_d;
      out_last_q  <= out_last_d;
      iter_idx_q  <= iter_idx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        tbl_col_q[i]   <= tbl_col_d[i];
        tbl_shift_q[i] <= tbl_shift_d[i];
      end
    end
  end

  assign out_valid = out_valid_q;
  assign qsn_shift = qsn_shift_q;
  assign out_col   = out_col_q;
  assign out_last  = out_last_q;
  assign iter_idx  = iter_idx_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: doc/qsn_layer_sched.md
Name: qsn_layer_sched

Overview:
- Sequences the quasi-cyclic shift network (QSN) in the LDPC datapath.
- Holds a small programmable table of base-matrix entries: column index, cyclic shift, null flag.
- On start, walks the table for a programmed number of iterations and issues one beat per non-null entry. Each beat carries the QSN shift amount and the column index.
- Beats leave over a valid/ready handshake to the message-memory/QSN stage. A done pulse marks the end.

Parameters:
- LIFTING_FACTOR, 4, QSN width; legal shifts are 0..LIFTING_FACTOR-1.
- SHIFT_WIDTH, 2, width of the shift field (clog2 LIFTING_FACTOR).
- NUM_ENTRIES, 8, table depth.
- ADDR_WIDTH, 3, clog2 NUM_ENTRIES.
- COL_WIDTH, 3, column-index width.
- ITER_WIDTH, 4, iteration-count width.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- cfg_we  in  1  table write strobe; honoured only in IDLE
- cfg_addr  in  ADDR_WIDTH  table entry written
- cfg_col  in  COL_WIDTH  column index for entry
- cfg_shift  in  SHIFT_WIDTH  cyclic shift for entry
- cfg_null  in  1  entry is a zero submatrix; skipped
- cfg_len  in  ADDR_WIDTH+1  active entries 0..NUM_ENTRIES; sampled at start
- iterations  in  ITER_WIDTH  iteration count; sampled at start
- start  in  1  begin schedule; honoured only in IDLE
- abort  in  1  terminate schedule
- out_valid  out  1  beat valid
- out_ready  in  1  downstream accepts beat
- qsn_shift  out  SHIFT_WIDTH  shift to drive into the QSN
- out_col  out  COL_WIDTH  column index of beat
- out_last  out  1  beat is the last non-null entry of the current iteration
- iter_idx  out  ITER_WIDTH  current iteration, 0-based
- busy  out  1  high in RUN and DONE
- done  out  1  single-cycle completion pulse

Behaviour:
- Reset: state IDLE, ptr=0, iter_idx=0. out_valid, out_last, busy and done are all 0; qsn_shift=0, out_col=0. Table entries reset to col=0, shift=0, null=1.
- All outputs are registered.
- Config:
  - cfg_we in IDLE writes the entry at the next edge.
  - cfg_we outside IDLE is ignored.
  - cfg_shift >= LIFTING_FACTOR is stored as cfg_shift mod LIFTING_FACTOR.
- FSM has 3 states: IDLE, RUN, DONE.
- IDLE leaves on start:
  - If cfg_len=0 or iterations=0 -> DONE. No beats are issued.
  - Otherwise -> RUN with ptr=0, iter_idx=0, and len/iterations latched.
- RUN pointer scan:
  - Each cycle in which no beat is pending, examine table[ptr].
  - Null entry: advance ptr with out_valid low. Costs 1 cycle per null entry.
  - Non-null entry: load out_valid=1 with qsn_shift, out_col and out_last, then advance ptr.
- Latency: the first beat is visible the cycle after the first non-null entry is examined. With entry 0 non-null, out_valid rises 2 cycles after the start edge.
- Handshake:
  - While out_valid && !out_ready, all beat fields are held stable and ptr does not advance.
  - A transfer occurs on out_valid && out_ready.
  - With out_ready tied high, throughput is 1 beat/cycle across consecutive non-null entries; back-to-back beats have no bubble.
- out_last is computed at load time: it is 1 iff no non-null entry remains at index > ptr within the latched len.
- Wrap-around: when ptr passes len-1, ptr goes to 0 and iter_idx increments.
  - If that completed iteration was iterations-1 -> DONE after the final transfer.
  - An all-null table still counts iterations, then reaches DONE with zero beats.
- DONE: lasts 1 cycle. done=1, out_valid=0, then -> IDLE. busy falls in IDLE.
- abort:
  - Abort in RUN -> DONE next cycle. out_valid drops even if a beat was pending; that beat is discarded.
  - Abort in IDLE is ignored.
  - Abort and start together in IDLE: start wins.
- start in RUN or DONE is ignored.
- Reset asserted mid-operation returns everything to reset values immediately. Table contents are reset as well.

Test Plan:
- Basic run: table = {0:(col1,sh2),1:(col3,sh0),2:(col0,sh3)}, len=3, iterations=2, out_ready=1 -> 6 beats with shifts 2,0,3,2,0,3 and cols 1,3,0,1,3,0. out_last is set on beats 3 and 6; iter_idx is 0 for beats 1-3 and 1 for beats 4-6; done pulses once, 1 cycle after beat 6.
- Null skip: entries 1 and 3 null, len=4, iterations=1 -> 2 beats (entries 0 and 2). out_last is set on entry 2's beat; exactly 1 bubble cycle between the two beats.
- Backpressure: out_ready low for 3 cycles while beat 1 is valid -> fields stay constant for those 3 cycles, no beat is lost or duplicated, and the total beat count is unchanged.
- Degenerate: len=0 with iterations=5 -> done pulse at start+1 with no out_valid. Separately, iterations=0 -> same result.
- Abort: assert abort while beat 2 of 6 is pending -> out_valid low the next cycle, done=1 once, then IDLE. A subsequent start reruns from entry 0, iteration 0.
- Config guard: cfg_we with shift=3 while busy -> the table is unchanged on the next run. cfg_we with shift=5 while IDLE (LIFTING_FACTOR=4, SHIFT_WIDTH=3) -> stored and emitted as 1.
